// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - requester and data-memory bundle for the two-port data memory arbiter
interface data_mem_arbiter_if;
  // requester side: bit/slice i belongs to requester i (0 = cpu, 1 = dma)
  logic [1:0]  req;
  logic [1:0]  req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_sign_mask;
  logic [1:0]  ack;
  logic [31:0] rdata;
  logic        err;
  logic        busy;
  logic        grant_id;
  // data memory side
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_sign_mask;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [31:0] mem_read_data;
  logic        mem_clk_stall;

  modport slave (
    input  req, req_we, req_addr, req_wdata, req_sign_mask, mem_read_data, mem_clk_stall,
    output ack, rdata, err, busy, grant_id,
           mem_addr, mem_write_data, mem_sign_mask, mem_memread, mem_memwrite
  );

  modport master (
    output req, req_we, req_addr, req_wdata, req_sign_mask, mem_read_data, mem_clk_stall,
    input  ack, rdata, err, busy, grant_id,
           mem_addr, mem_write_data, mem_sign_mask, mem_memread, mem_memwrite
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - cpu/dma arbiter in front of a stalling data memory, one transaction at a time
module data_mem_arbiter #(
  parameter bit CPU_PRIORITY   = 1'b1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  data_mem_arbiter_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    mask_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          grant_q;
  logic          last_grant;
  logic          stall_seen;
  logic [CW-1:0] wait_cnt;

  logic          winner;
  logic [CW-1:0] cnt_next;
  logic          done;
  logic          timed_out;

  // Pick the requester to serve; only meaningful while some req bit is set.
  // Round-robin hands a contended grant to whoever was not served last.
  always_comb begin
    winner = 1'b0;
    if (CPU_PRIORITY || !(&bus.req)) begin
      winner = ~bus.req[0];
    end else begin
      winner = ~last_grant;
    end
  end

  // The memory has finished once it has stalled at least once and then released.
  always_comb begin
    cnt_next  = wait_cnt + CW'(1);
    done      = stall_seen && !bus.mem_clk_stall;
    timed_out = (cnt_next == CW'(TIMEOUT_CYCLES));
  end

  // Transaction sequencer: latch the winner, strobe once, wait for the memory, respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      grant_q    <= 1'b0;
      last_grant <= 1'b1;
      stall_seen <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if ((bus.req != 2'b00) && !bus.mem_clk_stall) begin
            grant_q <= winner;
            we_q    <= bus.req_we[winner];
            addr_q  <= winner ? bus.req_addr[63:32]     : bus.req_addr[31:0];
            wdata_q <= winner ? bus.req_wdata[63:32]    : bus.req_wdata[31:0];
            mask_q  <= winner ? bus.req_sign_mask[7:4]  : bus.req_sign_mask[3:0];
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          stall_seen <= 1'b0;
          wait_cnt   <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= cnt_next;
          if (bus.mem_clk_stall) begin
            stall_seen <= 1'b1;
          end
          // A genuine completion takes precedence over a timeout hitting the same cycle.
          if (done) begin
            rdata_q <= we_q ? 32'h0 : bus.mem_read_data;
            err_q   <= 1'b0;
            state   <= S_RESP;
          end else if (timed_out) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b1;
            state   <= S_RESP;
          end
        end
        default: begin
          last_grant <= grant_q;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack            = (state == S_RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rdata          = rdata_q;
  assign bus.err            = err_q;
  assign bus.busy           = (state != S_IDLE);
  assign bus.grant_id       = grant_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.mem_sign_mask  = mask_q;
  assign bus.mem_memread    = (state == S_ISSUE) && !we_q;
  assign bus.mem_memwrite   = (state == S_ISSUE) && we_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter (round-robin and cpu-priority builds)
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_arbiter_if bus ();
  data_mem_arbiter_if pbus ();

  data_mem_arbiter #(.CPU_PRIORITY(1'b0), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  data_mem_arbiter #(.CPU_PRIORITY(1'b1), .TIMEOUT_CYCLES(16)) dut_p (
    .clk(clk), .rst_n(rst_n), .bus(pbus)
  );

  typedef struct {
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        err;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } exp_t;

  exp_t sb[$];
  logic psb[$];

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  bit hold_stall = 1'b0;
  bit no_stall = 1'b0;
  int n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic id, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] mask,
                      input logic [31:0] rd, input logic er);
    exp_t e;
    e.ack   = id ? 2'b10 : 2'b01;
    e.rdata = rd;
    e.err   = er;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.mask  = mask;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask);
    bus.req_we[i]               = we;
    bus.req_addr[i*32 +: 32]    = addr;
    bus.req_wdata[i*32 +: 32]   = wdata;
    bus.req_sign_mask[i*4 +: 4] = mask;
  endtask

  // Raise r, then drop each bit as its ack arrives; n counts negedges until the last ack.
  task automatic drive(input logic [1:0] r, output int cnt);
    @(negedge clk);
    bus.req = r;
    cnt = 0;
    while (bus.req != 2'b00 && cnt < 200) begin
      @(negedge clk);
      cnt++;
      bus.req = bus.req & ~bus.ack;
    end
    if (bus.req != 2'b00) begin
      checks++;
      failures++;
      $display("FAIL ack_wait actual=req_still_%b required=all_acked", bus.req);
      bus.req = 2'b00;
    end
  endtask

  task automatic drive_p(input logic [1:0] r);
    int cnt;
    @(negedge clk);
    pbus.req = r;
    cnt = 0;
    while (pbus.req != 2'b00 && cnt < 200) begin
      @(negedge clk);
      cnt++;
      pbus.req = pbus.req & ~pbus.ack;
    end
    if (pbus.req != 2'b00) begin
      checks++;
      failures++;
      $display("FAIL prio_ack_wait actual=req_still_%b required=all_acked", pbus.req);
      pbus.req = 2'b00;
    end
  endtask

  // Memory: after a strobe, stall for two WAIT-visible cycles (unless disabled or held).
  task automatic mem_model();
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_memread || bus.mem_memwrite) cnt = no_stall ? 0 : 3;
      else if (cnt > 0) cnt--;
      bus.mem_clk_stall = hold_stall || (cnt > 0);
    end
  endtask

  task automatic mem_model_p();
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (pbus.mem_memread || pbus.mem_memwrite) cnt = 3;
      else if (cnt > 0) cnt--;
      pbus.mem_clk_stall = (cnt > 0);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.mem_memread) rd_cnt++;
      if (bus.mem_memwrite) wr_cnt++;
      if (bus.ack != 2'b00) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack actual=%b required=none", bus.ack);
        end else begin
          e = sb.pop_front();
          check("ack", bus.ack, e.ack);
          check("rdata", bus.rdata, e.rdata);
          check("err", bus.err, e.err);
          check("mem_addr_held", bus.mem_addr, e.addr);
          check("mem_wdata_held", bus.mem_write_data, e.wdata);
          check("mem_mask_held", bus.mem_sign_mask, e.mask);
          check("read_strobes", rd_cnt, e.we ? 0 : 1);
          check("write_strobes", wr_cnt, e.we ? 1 : 0);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  endtask

  task automatic monitor_p();
    logic id;
    forever begin
      @(negedge clk);
      if (pbus.ack != 2'b00) begin
        if (psb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL prio_unexpected_ack actual=%b required=none", pbus.ack);
        end else begin
          id = psb.pop_front();
          check("prio_grant", pbus.ack, id ? 2'b10 : 2'b01);
        end
      end
    end
  endtask

  initial begin
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_sign_mask = '0; bus.mem_read_data = '0; bus.mem_clk_stall = 1'b0;
    pbus.req = '0; pbus.req_we = '0; pbus.req_addr = '0; pbus.req_wdata = '0;
    pbus.req_sign_mask = '0; pbus.mem_read_data = '0; pbus.mem_clk_stall = 1'b0;

    fork
      mem_model();
      mem_model_p();
      monitor();
      monitor_p();
      begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
      end
    join_none

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ack", bus.ack, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_err", bus.err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_grant", bus.grant_id, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_write_data, 0);
    check("rst_mem_mask", bus.mem_sign_mask, 0);
    check("rst_strobes", {bus.mem_memread, bus.mem_memwrite}, 0);
    rst_n = 1'b1;

    // cpu read with nominal latency
    set_req(0, 1'b0, 32'h1004, 32'h0, 4'hF);
    bus.mem_read_data = 32'hDEAD_BEEF;
    push(1'b0, 1'b0, 32'h1004, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
    drive(2'b01, n);
    check("read_latency", n, 5);

    // dma write
    set_req(1, 1'b1, 32'h2000, 32'h0000_00A5, 4'h1);
    push(1'b1, 1'b1, 32'h2000, 32'h0000_00A5, 4'h1, 32'h0, 1'b0);
    drive(2'b10, n);
    check("write_latency", n, 5);

    // contention, round-robin: dma was served last, so cpu then dma, twice
    bus.mem_read_data = 32'h1234_5678;
    set_req(0, 1'b0, 32'h3000, 32'h0, 4'h3);
    set_req(1, 1'b1, 32'h4000, 32'h55AA, 4'hC);
    for (int r = 0; r < 2; r++) begin
      push(1'b0, 1'b0, 32'h3000, 32'h0, 4'h3, 32'h1234_5678, 1'b0);
      push(1'b1, 1'b1, 32'h4000, 32'h55AA, 4'hC, 32'h0, 1'b0);
      drive(2'b11, n);
    end

    // cpu served alone, so the next contention goes to dma first
    push(1'b0, 1'b0, 32'h3000, 32'h0, 4'h3, 32'h1234_5678, 1'b0);
    drive(2'b01, n);
    push(1'b1, 1'b1, 32'h4000, 32'h55AA, 4'hC, 32'h0, 1'b0);
    push(1'b0, 1'b0, 32'h3000, 32'h0, 4'h3, 32'h1234_5678, 1'b0);
    drive(2'b11, n);

    // memory never stalls: timeout after 16 WAIT cycles
    no_stall = 1'b1;
    set_req(0, 1'b0, 32'h6000, 32'h0, 4'hF);
    push(1'b0, 1'b0, 32'h6000, 32'h0, 4'hF, 32'h0, 1'b1);
    drive(2'b01, n);
    check("timeout_latency", n, 18);
    no_stall = 1'b0;

    // normal transaction after a timeout
    bus.mem_read_data = 32'hCAFE_F00D;
    set_req(1, 1'b0, 32'h7000, 32'h0, 4'h7);
    push(1'b1, 1'b0, 32'h7000, 32'h0, 4'h7, 32'hCAFE_F00D, 1'b0);
    drive(2'b10, n);
    check("post_timeout_latency", n, 5);

    // reset in WAIT with the memory stalled: dropped, then served after the stall clears
    set_req(0, 1'b0, 32'h8000, 32'h0, 4'h5);
    bus.mem_read_data = 32'h0BAD_F00D;
    @(negedge clk);
    bus.req = 2'b01;
    @(negedge clk);
    hold_stall = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ack", bus.ack, 0);
    check("mid_rst_mem_addr", bus.mem_addr, 0);
    check("mid_rst_rdata", bus.rdata, 0);
    check("mid_rst_grant", bus.grant_id, 0);
    rd_cnt = 0;
    wr_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("stalled_no_issue", rd_cnt + wr_cnt, 0);
    check("stalled_idle", bus.busy, 0);
    hold_stall = 1'b0;
    push(1'b0, 1'b0, 32'h8000, 32'h0, 4'h5, 32'h0BAD_F00D, 1'b0);
    drive(2'b01, n);

    // cpu-priority build: cpu wins every contention even right after being served
    for (int r = 0; r < 2; r++) begin
      psb.push_back(1'b0);
      drive_p(2'b01);
      psb.push_back(1'b0);
      psb.push_back(1'b1);
      drive_p(2'b11);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("prio_sb_drained", psb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
